// File: rtl/msx_joy_pkg.sv
// Shared types, packet field positions and helpers for the MSX joystick-port
// mouse reader.
package msx_joy_pkg;

  // Poll sequencer: idle wait, four strobe phases (one nibble each), emit.
  typedef enum logic [2:0] {
    IDLE,
    XH,
    XL,
    YH,
    YL,
    EMIT
  } mrd_state_t;

  // ps2_mouse packet layout: [24] toggle, [23:16] Y, [15:8] X, [7:0] flags.
  localparam int PS2M_TOG    = 24;
  localparam int PS2M_Y_HI   = 23;
  localparam int PS2M_Y_LO   = 16;
  localparam int PS2M_X_HI   = 15;
  localparam int PS2M_X_LO   = 8;
  localparam int PS2M_F_HI   = 7;
  localparam int PS2M_F_LO   = 0;

  // Flag byte bit positions.
  localparam int PS2M_F_LEFT  = 0;
  localparam int PS2M_F_RIGHT = 1;
  localparam int PS2M_F_ONE   = 3;
  localparam int PS2M_F_XSGN  = 4;
  localparam int PS2M_F_YSGN  = 5;

  // Two's-complement negation that clamps -128 to +127 instead of wrapping.
  function automatic logic [7:0] sat_neg(input logic [7:0] v);
    if (v == 8'h80) begin
      return 8'h7F;
    end
    return (~v) + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a selectable
// reset level so idle-high pins do not glitch low out of reset.
module sync_2ff #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Shift raw pin levels through two flops before anyone looks at them.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // NOTE: sequential state uses <= so both flops sample the old values
      // on the same edge; a blocking = here would collapse them into one.
      meta_q <= {WIDTH{RESET_VAL}};
      sync_q <= {WIDTH{RESET_VAL}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/msx_mouse_reader.sv
// Initiator for the MSX joystick-port mouse: periodically toggles the strobe
// pin, reads X/Y as four nibbles plus the two buttons, and republishes the
// result in ps2_mouse packet format.
module msx_mouse_reader
  import msx_joy_pkg::*;
#(
  parameter int SETTLE_CYC = 1074,
  parameter int POLL_CYC   = 358000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic [5:0]  joy_in,
  output logic        strobe,
  output logic [24:0] ps2_mouse,
  output logic        busy
);

  localparam int PCW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int SCW = $clog2(SETTLE_CYC);

  localparam logic [PCW-1:0] POLL_LAST   = PCW'(POLL_CYC - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

  mrd_state_t     state_q, state_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic [SCW-1:0] phase_cnt_q, phase_cnt_d;
  logic [15:0]    nib_q, nib_d;         // {XH, XL, YH, YL} once all four land
  logic [1:0]     btn_cap_q, btn_cap_d; // {R, L} captured this poll
  logic [1:0]     btn_last_q, btn_last_d; // {R, L} last published
  logic [24:0]    ps2_q, ps2_d;

  logic [5:0]     joy_sync;
  logic           poll_last;
  logic           phase_last;
  logic           in_phase;
  logic [7:0]     x_out;
  logic [7:0]     y_out;
  logic           changed;

  sync_2ff #(
    .WIDTH     (6),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d_i     (joy_in),
    .q_o     (joy_sync)
  );

  // Next-state, capture and packet update logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d     = state_q;
    poll_cnt_d  = poll_cnt_q;
    phase_cnt_d = phase_cnt_q;
    nib_d       = nib_q;
    btn_cap_d   = btn_cap_q;
    btn_last_d  = btn_last_q;
    ps2_d       = ps2_q;
    strobe      = 1'b0;

    poll_last  = (poll_cnt_q == POLL_LAST);
    phase_last = (phase_cnt_q == SETTLE_LAST);
    in_phase   = (state_q == XH) || (state_q == XL) ||
                 (state_q == YH) || (state_q == YL);

    // Mouse reports positive = left/up; PS/2 wants positive = right.
    x_out   = sat_neg(nib_q[15:8]);
    y_out   = nib_q[7:0];
    changed = (x_out != 8'h00) || (y_out != 8'h00) || (btn_cap_q != btn_last_q);

    // Poll period runs through the whole poll so starts stay POLL_CYC apart;
    // it is held clear while polling is disabled.
    if (!enable || poll_last) begin
      poll_cnt_d = '0;
    end else begin
      poll_cnt_d = poll_cnt_q + 1'b1;
    end

    if (in_phase) begin
      phase_cnt_d = phase_last ? '0 : phase_cnt_q + 1'b1;
    end else begin
      phase_cnt_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (enable && poll_last) begin
          state_d = XH;
        end
      end

      XH: begin
        strobe = 1'b1;
        if (phase_last) begin
          nib_d   = {nib_q[11:0], joy_sync[3:0]};
          state_d = XL;
        end
      end

      XL: begin
        if (phase_last) begin
          nib_d   = {nib_q[11:0], joy_sync[3:0]};
          state_d = YH;
        end
      end

      YH: begin
        strobe = 1'b1;
        if (phase_last) begin
          nib_d   = {nib_q[11:0], joy_sync[3:0]};
          state_d = YL;
        end
      end

      YL: begin
        if (phase_last) begin
          nib_d     = {nib_q[11:0], joy_sync[3:0]};
          btn_cap_d = {~joy_sync[5], ~joy_sync[4]};
          state_d   = EMIT;
        end
      end

      EMIT: begin
        if (changed) begin
          ps2_d[PS2M_TOG]             = ~ps2_q[PS2M_TOG];
          ps2_d[PS2M_Y_HI:PS2M_Y_LO]  = y_out;
          ps2_d[PS2M_X_HI:PS2M_X_LO]  = x_out;
          ps2_d[PS2M_F_HI:PS2M_F_LO]  = 8'h00;
          ps2_d[PS2M_F_LEFT]          = btn_cap_q[0];
          ps2_d[PS2M_F_RIGHT]         = btn_cap_q[1];
          ps2_d[PS2M_F_ONE]           = 1'b1;
          ps2_d[PS2M_F_XSGN]          = x_out[7];
          ps2_d[PS2M_F_YSGN]          = y_out[7];
          btn_last_d                  = btn_cap_q;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Losing enable mid-poll abandons it: no publish, partial data dropped.
    if (!enable && (state_q != IDLE)) begin
      state_d     = IDLE;
      phase_cnt_d = '0;
      nib_d       = '0;
      btn_cap_d   = btn_cap_q;
      btn_last_d  = btn_last_q;
      ps2_d       = ps2_q;
    end

    busy = (state_q != IDLE);
  end

  // State, counters and packet register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      poll_cnt_q  <= '0;
      phase_cnt_q <= '0;
      nib_q       <= '0;
      btn_cap_q   <= '0;
      btn_last_q  <= '0;
      ps2_q       <= '0;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      nib_q       <= nib_d;
      btn_cap_q   <= btn_cap_d;
      btn_last_q  <= btn_last_d;
      ps2_q       <= ps2_d;
    end
  end

  assign ps2_mouse = ps2_q;

endmodule
